// File: rtl/pmu_event_serializer.sv
// pmu_event_serializer
//
// Feeds the PMU event inputs. Each event lane accepts a multi-bit increment
// per cycle. The PMU counters can only advance by one per cycle per line, so
// this block keeps the surplus in a per-lane saturating backlog. It then
// replays that backlog as one single-cycle pulse per clock on the matching
// PMU event line.
//
// Parameters:
//   N_EVENTS  - number of event lanes (one per PMU counter)
//   IN_W      - width of each lane's per-cycle increment
//   BACKLOG_W - width of each lane's backlog counter (must be >= IN_W)
//
// Ports:
//   S_AXI_ACLK_i    - clock shared with the PMU
//   S_AXI_ARESETN_i - asynchronous active-low reset
//   inc_i           - packed increments, lane k at inc_i[k*IN_W +: IN_W]
//   en_i            - per-lane accept enable (backlog still drains when low)
//   clear_i         - synchronous clear of all backlogs and loss flags
//   events_o        - registered one-pulse-per-cycle event lines, bit k -> EVk
//   pending_o       - registered, lane backlog is non-zero
//   lost_o          - registered sticky per-lane saturation flag
//   lost_any_o      - OR of lost_o

module pmu_event_serializer #(
  parameter int N_EVENTS  = 19,
  parameter int IN_W      = 2,
  parameter int BACKLOG_W = 4
) (
  input  logic                     S_AXI_ACLK_i,
  input  logic                     S_AXI_ARESETN_i,
  input  logic [N_EVENTS*IN_W-1:0] inc_i,
  input  logic [N_EVENTS-1:0]      en_i,
  input  logic                     clear_i,
  output logic [N_EVENTS-1:0]      events_o,
  output logic [N_EVENTS-1:0]      pending_o,
  output logic [N_EVENTS-1:0]      lost_o,
  output logic                     lost_any_o
);

  // One extra bit holds backlog + increment without wrapping.
  localparam int SUM_W = BACKLOG_W + 1;

  // A sum above 2^BACKLOG_W means sum-1 no longer fits in the backlog.
  localparam logic [SUM_W-1:0] SAT_SUM = SUM_W'(2 ** BACKLOG_W);

  logic [N_EVENTS-1:0][BACKLOG_W-1:0] backlog_q, backlog_d;
  logic [N_EVENTS-1:0]                events_q,  events_d;
  logic [N_EVENTS-1:0]                pending_q, pending_d;
  logic [N_EVENTS-1:0]                lost_q,    lost_d;

  // Per-lane accumulate/drain. Each lane emits one pulse whenever it has
  // anything to report and keeps the rest. clear_i overrides everything,
  // including a saturation in the same cycle.
  always_comb begin
    backlog_d = backlog_q;
    events_d  = '0;
    pending_d = '0;
    lost_d    = lost_q;

    for (int k = 0; k < N_EVENTS; k++) begin
      logic [SUM_W-1:0] inc_eff;
      logic [SUM_W-1:0] sum;

      inc_eff = en_i[k] ? SUM_W'(inc_i[k*IN_W +: IN_W]) : '0;
      sum     = SUM_W'(backlog_q[k]) + inc_eff;

      if (sum == '0) begin
        backlog_d[k] = '0;
        events_d[k]  = 1'b0;
      end else begin
        events_d[k] = 1'b1;
        if (sum > SAT_SUM) begin
          backlog_d[k] = '1;
          lost_d[k]    = 1'b1;
        end else begin
          backlog_d[k] = BACKLOG_W'(sum - SUM_W'(1));
        end
      end

      pending_d[k] = (backlog_d[k] != '0);
    end

    if (clear_i) begin
      backlog_d = '0;
      events_d  = '0;
      pending_d = '0;
      lost_d    = '0;
    end
  end

  always_ff @(posedge S_AXI_ACLK_i or negedge S_AXI_ARESETN_i) begin
    if (!S_AXI_ARESETN_i) begin
      backlog_q <= '0;
      events_q  <= '0;
      pending_q <= '0;
      lost_q    <= '0;
    end else begin
      backlog_q <= backlog_d;
      events_q  <= events_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
    end
  end

  assign events_o   = events_q;
  assign pending_o  = pending_q;
  assign lost_o     = lost_q;
  assign lost_any_o = |lost_q;

endmodule

// File: tb/tb_pmu_event_serializer.sv
// tb_pmu_event_serializer
//
// Directed bench for pmu_event_serializer with the default parameters.
// Stimulus pushes the hand-computed outputs expected after each clock into
// a queue. A separate monitor pops one entry per clock and compares it with
// the DUT outputs.

module tb_pmu_event_serializer;

  localparam int N    = 19;
  localparam int IN_W = 2;
  localparam int BW   = 4;

  logic                 clk;
  logic                 rst_n;
  logic [N*IN_W-1:0]    inc_i;
  logic [N-1:0]         en_i;
  logic                 clear_i;
  logic [N-1:0]         events_o;
  logic [N-1:0]         pending_o;
  logic [N-1:0]         lost_o;
  logic                 lost_any_o;

  localparam logic [N-1:0] ALL_EN = '1;

  typedef struct {
    logic [N-1:0] ev;
    logic [N-1:0] pend;
    logic [N-1:0] lost;
    logic         lany;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   pulse_cnt2 = 0;

  pmu_event_serializer #(
    .N_EVENTS (N),
    .IN_W     (IN_W),
    .BACKLOG_W(BW)
  ) dut (
    .S_AXI_ACLK_i   (clk),
    .S_AXI_ARESETN_i(rst_n),
    .inc_i          (inc_i),
    .en_i           (en_i),
    .clear_i        (clear_i),
    .events_o       (events_o),
    .pending_o      (pending_o),
    .lost_o         (lost_o),
    .lost_any_o     (lost_any_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int lane, input bit ev, input bit pend, input bit lost, input string tag);
    exp_t e;
    e.ev         = '0;
    e.pend       = '0;
    e.lost       = '0;
    e.ev[lane]   = ev;
    e.pend[lane] = pend;
    e.lost[lane] = lost;
    e.lany       = lost;
    e.tag        = tag;
    return e;
  endfunction

  function automatic exp_t mk_all(input bit ev, input bit pend, input bit lost, input string tag);
    exp_t e;
    e.ev   = {N{ev}};
    e.pend = {N{pend}};
    e.lost = {N{lost}};
    e.lany = lost;
    e.tag  = tag;
    return e;
  endfunction

  function automatic logic [N*IN_W-1:0] lane_inc(input int lane, input logic [IN_W-1:0] v);
    logic [N*IN_W-1:0] r;
    r = '0;
    r[lane*IN_W +: IN_W] = v;
    return r;
  endfunction

  function automatic logic [N*IN_W-1:0] all_inc(input logic [IN_W-1:0] v);
    logic [N*IN_W-1:0] r;
    for (int k = 0; k < N; k++) r[k*IN_W +: IN_W] = v;
    return r;
  endfunction

  // Drive one cycle of inputs and record what the outputs must look like
  // after the following rising edge.
  task automatic applyStimulus(input logic [N*IN_W-1:0] inc, input logic [N-1:0] en,
                               input logic clr, input exp_t e);
    @(negedge clk);
    inc_i   = inc;
    en_i    = en;
    clear_i = clr;
    sb.push_back(e);
  endtask

  // Monitor: one expectation is consumed per clock, just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (events_o[2] === 1'b1) pulse_cnt2++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({e.tag, ".events"},   32'(events_o),   32'(e.ev));
        checkOutput({e.tag, ".pending"},  32'(pending_o),  32'(e.pend));
        checkOutput({e.tag, ".lost"},     32'(lost_o),     32'(e.lost));
        checkOutput({e.tag, ".lost_any"}, 32'(lost_any_o), 32'(e.lany));
      end
    end
  end

  initial begin
    int cnt0;
    int waited;

    rst_n   = 1'b1;
    inc_i   = '0;
    en_i    = ALL_EN;
    clear_i = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    checkOutput("reset.events",   32'(events_o),   32'd0);
    checkOutput("reset.pending",  32'(pending_o),  32'd0);
    checkOutput("reset.lost",     32'(lost_o),     32'd0);
    checkOutput("reset.lost_any", 32'(lost_any_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single increment on lane 0: one pulse, no backlog.
    applyStimulus(lane_inc(0, 1), ALL_EN, 1'b0, mk(0, 1, 0, 0, "s1_pulse"));
    applyStimulus('0,             ALL_EN, 1'b0, mk(0, 0, 0, 0, "s1_idle"));

    // Increment of 3 on lane 5: three consecutive pulses.
    applyStimulus(lane_inc(5, 3), ALL_EN, 1'b0, mk(5, 1, 1, 0, "s2_c1"));
    applyStimulus('0,             ALL_EN, 1'b0, mk(5, 1, 1, 0, "s2_c2"));
    applyStimulus('0,             ALL_EN, 1'b0, mk(5, 1, 0, 0, "s2_c3"));
    applyStimulus('0,             ALL_EN, 1'b0, mk(5, 0, 0, 0, "s2_c4"));

    // Increment of 1 every cycle on lane 10: steady high, no backlog.
    for (int i = 0; i < 4; i++)
      applyStimulus(lane_inc(10, 1), ALL_EN, 1'b0, mk(10, 1, 0, 0, "cont_on"));
    applyStimulus('0, ALL_EN, 1'b0, mk(10, 0, 0, 0, "cont_off"));

    // Lane 7: build backlog 4, then disable it with input still offered.
    applyStimulus(lane_inc(7, 3), ALL_EN, 1'b0, mk(7, 1, 1, 0, "s4_load1"));
    applyStimulus(lane_inc(7, 3), ALL_EN, 1'b0, mk(7, 1, 1, 0, "s4_load2"));
    for (int i = 0; i < 3; i++)
      applyStimulus(lane_inc(7, 3), ALL_EN & ~(N'(1) << 7), 1'b0, mk(7, 1, 1, 0, "s4_drain"));
    applyStimulus(lane_inc(7, 3), ALL_EN & ~(N'(1) << 7), 1'b0, mk(7, 1, 0, 0, "s4_last"));
    applyStimulus(lane_inc(7, 3), ALL_EN & ~(N'(1) << 7), 1'b0, mk(7, 0, 0, 0, "s4_done1"));
    applyStimulus(lane_inc(7, 3), ALL_EN & ~(N'(1) << 7), 1'b0, mk(7, 0, 0, 0, "s4_done2"));

    // Saturation on lane 2: 24 offered, 23 delivered, sticky loss flag.
    cnt0 = pulse_cnt2;
    for (int i = 0; i < 8; i++)
      applyStimulus(lane_inc(2, 3), ALL_EN, 1'b0, mk(2, 1, 1, (i == 7), "s3_fill"));
    for (int k = 1; k <= 15; k++)
      applyStimulus('0, ALL_EN, 1'b0, mk(2, 1, (k < 15), 1, "s3_drain"));
    applyStimulus('0, ALL_EN, 1'b0, mk(2, 0, 0, 1, "s3_sticky1"));
    applyStimulus('0, ALL_EN, 1'b0, mk(2, 0, 0, 1, "s3_sticky2"));
    @(posedge clk);
    #2;
    checkOutput("s3_pulse_count", 32'(pulse_cnt2 - cnt0), 32'd23);
    applyStimulus('0, ALL_EN, 1'b1, mk(2, 0, 0, 0, "s3_clear"));

    // Clear while lane 2 backlog is 10; the increment in that cycle is dropped.
    for (int i = 0; i < 8; i++)
      applyStimulus(lane_inc(2, 3), ALL_EN, 1'b0, mk(2, 1, 1, (i == 7), "s5_fill"));
    for (int k = 1; k <= 5; k++)
      applyStimulus('0, ALL_EN, 1'b0, mk(2, 1, 1, 1, "s5_drain"));
    applyStimulus(lane_inc(2, 3), ALL_EN, 1'b1, mk(2, 0, 0, 0, "s5_clear"));
    applyStimulus('0, ALL_EN, 1'b0, mk(2, 0, 0, 0, "s5_after1"));
    applyStimulus('0, ALL_EN, 1'b0, mk(2, 0, 0, 0, "s5_after2"));

    // Clear in the same cycle that would saturate: loss flag must stay 0.
    for (int i = 0; i < 7; i++)
      applyStimulus(lane_inc(2, 3), ALL_EN, 1'b0, mk(2, 1, 1, 0, "sc_fill"));
    applyStimulus(lane_inc(2, 3), ALL_EN, 1'b1, mk(2, 0, 0, 0, "sc_clear"));
    applyStimulus('0, ALL_EN, 1'b0, mk(2, 0, 0, 0, "sc_after"));

    // All lanes busy, then asynchronous reset between edges.
    for (int i = 0; i < 5; i++)
      applyStimulus(all_inc(3), ALL_EN, 1'b0, mk_all(1, 1, 0, "s6_load"));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("s6_rst.events",   32'(events_o),   32'd0);
    checkOutput("s6_rst.pending",  32'(pending_o),  32'd0);
    checkOutput("s6_rst.lost",     32'(lost_o),     32'd0);
    checkOutput("s6_rst.lost_any", 32'(lost_any_o), 32'd0);
    repeat (2) @(negedge clk);
    inc_i = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus('0, ALL_EN, 1'b0, mk_all(0, 0, 0, "s6_after"));

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/pmu_event_serializer.md
# pmu_event_serializer

Upstream feeder for the AXI PMU event inputs. Cores report several occurrences of an event in one cycle, for example two retired instructions. The PMU counters advance by at most one per cycle per event line. This block accepts a multi-bit increment per event lane, keeps the surplus in a per-lane saturating backlog counter, and replays it as one single-cycle pulse per clock on the matching PMU event line, so no occurrence is lost unless the backlog saturates. Its `events_o` connects directly to the PMU event bus, bit k to EVk.

## Interface
Parameters:
- `N_EVENTS`, default 19: number of event lanes; equals the PMU counter count.
- `IN_W`, default 2: width of each lane's per-cycle increment (0..2^IN_W-1).
- `BACKLOG_W`, default 4: width of each lane's backlog counter. Constraint: BACKLOG_W >= IN_W.

Ports:
- `S_AXI_ACLK_i` in 1: the single clock, shared with the PMU.
- `S_AXI_ARESETN_i` in 1: reset, asynchronous, active-low.
- `inc_i` in N_EVENTS*IN_W: packed increments; lane k is `inc_i[k*IN_W +: IN_W]`.
- `en_i` in N_EVENTS: per-lane accept enable.
- `clear_i` in 1: synchronous clear of all backlogs and loss flags.
- `events_o` out N_EVENTS: registered one-pulse-per-cycle event lines to the PMU.
- `pending_o` out N_EVENTS: registered; 1 when lane backlog != 0.
- `lost_o` out N_EVENTS: registered sticky per-lane saturation flag.
- `lost_any_o` out 1: OR-reduction of `lost_o`; combinational from registers.

## Operation
Per lane k, each cycle, with b = backlog register (BACKLOG_W bits):
- `inc_eff` = `en_i[k]` ? `inc_i` lane : 0, zero-extended.
- `sum` = b + `inc_eff`, computed at BACKLOG_W+1 bits.
- If `sum` == 0: `events_o[k]` <= 0 and b <= 0.
- If `sum` > 0: `events_o[k]` <= 1 and b <= `sum`-1.
- Saturation: if `sum`-1 > 2^BACKLOG_W-1, then b <= 2^BACKLOG_W-1 and `lost_o[k]` <= 1. The excess is discarded and no loss count is kept.
- `pending_o[k]` <= (next b != 0).
- `en_i[k]` low blocks new input only; the existing backlog keeps draining at one pulse per cycle.
- `clear_i` high: all b <= 0, all `lost_o` <= 0, `events_o` <= 0, `pending_o` <= 0. Increments presented in that cycle are discarded.
- Lanes are fully independent; there is no cross-lane arbitration.

## Timing
- Reset (async assert): b, `events_o`, `pending_o` and `lost_o` all go to 0 immediately; `lost_any_o` = 0. Deassertion is taken synchronously by the clock.
- Latency: an increment sampled at edge t produces its first pulse on `events_o` in the cycle after t, i.e. 1 cycle.
- Throughput: at most 1 pulse per lane per cycle. An increment of n with an empty backlog gives n consecutive pulses.
- An increment of 1 every cycle with b=0 gives `events_o` continuously high; b stays 0.
- Priority: reset > `clear_i` > saturation/accumulate. `clear_i` coinciding with saturation leaves `lost_o` = 0.
- `lost_o` only sets; only `clear_i` or reset clears it.
- Reset mid-drain: the remaining backlog is dropped and no further pulses appear after reset.
- No handshake with the PMU: every pulse is assumed consumed in its cycle.

## Test plan
Defaults N_EVENTS=19, IN_W=2, BACKLOG_W=4 (backlog max 15):
1. **Single increment.** Lane 0 `inc`=1 for one cycle at t → `events_o[0]`=1 in cycle t+1 only; `pending_o[0]` stays 0; other lanes stay 0.
2. **Multi-count increment.** Lane 5 `inc`=3 at t → `events_o[5]` high cycles t+1..t+3 and low at t+4; `pending_o[5]` high t+1..t+2.
3. **Saturation.** Lane 2 `inc`=3 for 8 consecutive cycles → b sequence 2,4,…,14 then 15; `lost_o[2]`=1 and `lost_any_o`=1 from the 8th output cycle; 23 total pulses (24 offered, 1 lost); `lost_o[2]` stays 1 after the drain.
4. **Enable low while draining.** Lane 7 backlog 4, `en_i[7]`=0, `inc`=3 held → exactly 4 further pulses, then `events_o[7]`=0 and `pending_o[7]`=0.
5. **Clear mid-drain.** Lane 2 from scenario 3, `clear_i` pulse while b=10 → next cycle `events_o[2]`=0, `pending_o[2]`=0, `lost_o[2]`=0, `lost_any_o`=0; an increment presented in the clear cycle yields no pulse.
6. **Reset mid-operation.** All lanes `inc`=3 for 5 cycles, then assert `S_AXI_ARESETN_i`=0 between edges → all outputs 0 immediately; after release with `inc`=0, no pulses occur.
